// File: rtl/ifetch_pkg.sv
// Shared types and sizes for the instruction fetch unit.
package ifetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned FIFO_DEPTH  = 2;
  localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Two-entry fetch buffer holding {pc, instr}; flush wins over push/pop.
module ifetch_fifo
  import ifetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fetch_entry_t     data_i,
  output logic [CNT_W-1:0] count_o,
  output fetch_entry_t     head_o
);

  fetch_entry_t     mem_q [FIFO_DEPTH];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // A push into a full buffer is accepted only when the head leaves the same cycle.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CNT_W'(FIFO_DEPTH)) || do_pop);
    rd_ptr_d = rd_ptr_q ^ do_pop;
    wr_ptr_d = wr_ptr_q ^ do_push;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch.sv
// Sequential instruction fetch with one in-flight read and a 2-entry output buffer.
// Optional misaligned-redirect trap enabled by defining IFETCH_MISALIGN_CHK_EN.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] addrB_o,
  input  logic [XLEN-1:0] dataB_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            misalign_o
);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
  logic             inflight_v_q, inflight_v_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_head;
  fetch_entry_t     fifo_wdata;
  logic [CNT_W:0]   occupancy;
  logic             pop, push, issue;
  logic [XLEN-1:0]  target;
  logic             target_bad;

`ifdef IFETCH_MISALIGN_CHK_EN
  assign target     = redirect_pc_i;
  assign target_bad = |redirect_pc_i[1:0];
  assign misalign_o = misalign_q;
`else
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^redirect_pc_i[1:0];
  assign target         = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign target_bad     = 1'b0;
  assign misalign_o     = 1'b0;
`endif

  assign valid_o   = !rst && (fifo_count != '0);
  assign pop       = valid_o && ready_i;
  assign occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_v_q);
  assign push      = inflight_v_q && !redirect_i;
  assign addrB_o   = pc_q;

  // Buffer slots are reserved at issue time so the returning word always has room.
  always_comb begin
    issue = 1'b0;
    if ((occupancy < (CNT_W+1)'(FIFO_DEPTH)) ||
        ((occupancy == (CNT_W+1)'(FIFO_DEPTH)) && pop)) begin
      issue = !redirect_i && !misalign_q && !rst;
    end
  end

  always_comb begin
    pc_d          = pc_q;
    inflight_v_d  = issue;
    inflight_pc_d = pc_q;
    misalign_d    = misalign_q;
    if (issue) begin
      pc_d = pc_q + XLEN'(INSTR_BYTES);
    end
    if (redirect_i) begin
      pc_d         = target;
      inflight_v_d = 1'b0;
      misalign_d   = target_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_v_q  <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_v_q  <= inflight_v_d;
      misalign_q    <= misalign_d;
    end
  end

  assign fifo_wdata = '{pc: inflight_pc_q, instr: dataB_i};

  ifetch_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .data_i  (fifo_wdata),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  assign pc_o    = fifo_head.pc;
  assign instr_o = fifo_head.instr;

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port addrB_o  output  32  fetch address to memory read port B.
REQ-005 SHALL have port dataB_i  input  32  memory port B read data, registered, valid one cycle after address.
REQ-006 SHALL have port ready_i  input  1  downstream accepts instruction this cycle.
REQ-007 SHALL have port valid_o  output  1  instr_o/pc_o hold a valid fetched instruction.
REQ-008 SHALL have port instr_o  output  32  fetched instruction word.
REQ-009 SHALL have port pc_o  output  32  address of instr_o.
REQ-010 SHALL have port redirect_i  input  1  flush and restart fetch at redirect_pc_i.
REQ-011 SHALL have port redirect_pc_i  input  32  redirect target.
REQ-012 SHALL have port misalign_o  output  1  sticky misaligned-redirect flag.

Function
REQ-013 SHALL hold pc_q and drive addrB_o = pc_q combinationally every cycle.
REQ-014 SHALL issue a fetch in a cycle when (fifo_count + inflight_v) < 2, or == 2 with a pop (valid_o & ready_i) in the same cycle; a non-redirect issue increments pc_q by 4, wrapping 32'hFFFF_FFFC -> 0.
REQ-015 SHALL track one in-flight entry {inflight_v, inflight_pc}; the cycle after an issue, {inflight_pc, dataB_i} SHALL be written into a 2-entry FIFO.
REQ-016 SHALL drive valid_o = FIFO non-empty and instr_o/pc_o = FIFO head; no bypass; issue-to-valid_o latency 2 cycles.
REQ-017 SHALL pop the FIFO head when valid_o & ready_i; the head SHALL stay stable while valid_o & !ready_i.
REQ-018 SHALL sustain one instruction per cycle with ready_i held high.
REQ-019 SHALL never overflow the FIFO; push and pop in the same cycle at count 2 is legal.
REQ-020 On redirect_i: in that cycle FIFO cleared, in-flight response discarded next cycle, pc_q <= redirect_pc_i, no issue; valid_o low the next cycle; target issued the next cycle; target valid_o 3 cycles after redirect_i asserted.
REQ-021 A pop coincident with redirect_i SHALL count as consumed; redirect overrides all other updates.
REQ-022 Back-to-back redirects SHALL honour only the latest target.

Reset
REQ-023 rst SHALL set pc_q = RESET_PC, FIFO empty, inflight_v = 0, misalign_o = 0; valid_o = 0 while rst high and one cycle after.
REQ-024 rst SHALL take priority over redirect_i and over any in-flight fetch; first issue in the cycle after rst deasserts.

Configuration
REQ-025 Macro IFETCH_MISALIGN_CHK_EN: when defined, a redirect with redirect_pc_i[1:0] != 0 SHALL set misalign_o, clear FIFO/in-flight and stop issuing until a later aligned redirect, which clears misalign_o.
REQ-026 When IFETCH_MISALIGN_CHK_EN is undefined, redirect_pc_i[1:0] SHALL be forced to 2'b00 and misalign_o tied to 0.

Structure
REQ-027 Shared package SHALL define XLEN = 32, INSTR_BYTES = 4, and typedef fetch_entry_t {pc, instr}.
REQ-028 The 2-entry FIFO SHALL be a sub-module ifetch_fifo (push/pop/flush, count, head); the remainder stays in ifetch.

Verification
REQ-029 Reset, RESET_PC = 0x0, ready_i = 1, memory word k = 0x1000+k -> valid_o first high 2 cycles after rst falls; pc_o 0,4,8,... with instr_o 0x1000,0x1001,... one per cycle.
REQ-030 ready_i low for 5 cycles mid-stream -> valid_o stays high, instr_o/pc_o unchanged, addrB_o stops advancing; no instruction lost or duplicated after ready_i rises.
REQ-031 redirect_i to 0x40 while FIFO full -> valid_o low next cycle; addrB_o = 0x40 next cycle; pc_o = 0x40 valid 3 cycles after redirect; no pre-redirect pc appears afterwards.
REQ-032 redirect_i on consecutive cycles to 0x20 then 0x30 -> only 0x30, 0x34, ... delivered.
REQ-033 pc_q = 0xFFFF_FFF8, ready_i = 1 -> pc_o sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-034 With IFETCH_MISALIGN_CHK_EN, redirect to 0x42 -> misalign_o = 1, valid_o = 0, no further deliveries; redirect to 0x44 clears misalign_o, pc_o = 0x44 delivered. Without it, redirect to 0x42 delivers pc_o = 0x40.
